// File: rtl/fmap_stream_reader.sv
// Replays a captured feature map from the 256-bit result BRAM as an AXI-Stream pixel stream.
// Column-major order, 16 pixels per word; a 2-entry word FIFO absorbs BRAM latency and back-pressure.
module fmap_stream_reader #(
  parameter int          DATA_WIDTH = 16,
  parameter int          PIX_H      = 24,
  parameter int          PIX_W      = 24,
  parameter int          NUM_CH     = 4,
  parameter logic [11:0] BASE_ADDR  = 12'h000,
  parameter int          CH_STRIDE  = 48,
  parameter int          RD_LATENCY = 1
) (
  input  logic                      out_stream_aclk,
  input  logic                      periph_resetn,
  input  logic                      start,
  input  logic [$clog2(NUM_CH):0]   ch_sel,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [11:0]               bram_addr_b,
  output logic                      bram_en_b,
  input  logic [255:0]              bram_rddata_b,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser
);

  localparam int LANES         = 256 / DATA_WIDTH;
  localparam int LANE_W        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORDS_PER_COL = (PIX_H + LANES - 1) / LANES;
  localparam int TOTAL_WORDS   = PIX_W * WORDS_PER_COL;
  localparam int WORD_W        = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam int ROW_W         = (PIX_H > 1) ? $clog2(PIX_H) : 1;
  localparam int COL_W         = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam int CH_W          = $clog2(NUM_CH) + 1;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(PIX_H - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PIX_W - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(TOTAL_WORDS - 1);
  localparam logic [CH_W-1:0]   NUM_CH_V  = CH_W'(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

  state_t                 state_q, state_d;
  logic [11:0]            rd_addr_q, rd_addr_d;
  logic [WORD_W-1:0]      rd_word_q, rd_word_d;
  logic [RD_LATENCY-1:0]  rd_vld_q, rd_vld_d;
  logic [255:0]           fifo_mem_q [2];
  logic [255:0]           fifo_mem_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   ch_bad;
  logic [11:0]            base_addr;
  logic [1:0]             inflight;
  logic [2:0]             occ;
  logic                   rd_issue;
  logic                   push;
  logic                   beat_hs;
  logic                   word_pop;
  logic                   last_beat;
  logic [255:0]           head_word;

  assign accept    = (state_q == S_IDLE) && start;
  assign ch_bad    = ch_sel >= NUM_CH_V;
  assign base_addr = 12'(int'(BASE_ADDR) + int'(ch_sel) * CH_STRIDE);
  assign push      = rd_vld_q[RD_LATENCY-1];
  assign beat_hs   = m_axis_tvalid && m_axis_tready;
  assign word_pop  = beat_hs && ((lane_q == LANE_LAST) || (row_q == ROW_LAST));
  assign last_beat = beat_hs && (state_q == S_DRAIN) && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign head_word = fifo_mem_q[rd_ptr_q];

  // Words buffered plus words still travelling through the BRAM pipeline
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {1'b0, rd_vld_q[i]};
    end
    occ = {1'b0, fifo_cnt_q} + {1'b0, inflight};
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = ch_bad ? S_ERR : S_RUN;
      S_RUN:   if (rd_issue && (rd_word_q == WORD_LAST)) state_d = S_DRAIN;
      S_DRAIN: if (last_beat) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_issue      = (state_q == S_RUN) && (occ < 3'd2);
    bram_en_b     = rd_issue;
    bram_addr_b   = rd_issue ? rd_addr_q : '0;
    m_axis_tvalid = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (fifo_cnt_q != 2'd0);
    m_axis_tdata  = m_axis_tvalid ? head_word[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    m_axis_tlast  = m_axis_tvalid && (row_q == ROW_LAST);
    m_axis_tuser  = m_axis_tvalid && (row_q == '0) && (col_q == '0);
    busy          = busy_q;
    done          = done_q;
    err           = err_q;
  end

  always_comb begin
    rd_addr_d   = rd_addr_q;
    rd_word_d   = rd_word_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    lane_d      = lane_q;
    row_d       = row_q;
    col_d       = col_q;
    fifo_mem_d  = fifo_mem_q;
    rd_vld_d[0] = rd_issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
    end

    if (accept) begin
      rd_addr_d = base_addr;
      rd_word_d = '0;
      lane_d    = '0;
      row_d     = '0;
      col_d     = '0;
    end else begin
      if (rd_issue) begin
        rd_addr_d = rd_addr_q + 12'd1;
        rd_word_d = rd_word_q + WORD_W'(1);
      end
      if (beat_hs) begin
        if (row_q == ROW_LAST) begin
          row_d  = '0;
          lane_d = '0;
          col_d  = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end else begin
          row_d  = row_q + ROW_W'(1);
          lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + LANE_W'(1);
        end
      end
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = bram_rddata_b;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (word_pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, word_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_ERR) || last_beat;
    if (accept)                 err_d = 1'b0;
    else if (state_q == S_ERR)  err_d = 1'b1;
    else                        err_d = err_q;
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      rd_addr_q  <= '0;
      rd_word_q  <= '0;
      rd_vld_q   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
      lane_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_word_q  <= rd_word_d;
      rd_vld_q   <= rd_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      lane_q     <= lane_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Word storage carries no control meaning, so it is left out of reset
  always_ff @(posedge out_stream_aclk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: one instance at read latency 1, one at read latency 2.
module tb_fmap_stream_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, start2;
  logic [2:0]   ch_sel, ch_sel2;
  logic         busy, done, err, en, tvalid, tready, tlast, tuser;
  logic         busy2, done2, err2, en2, tvalid2, tready2, tlast2, tuser2;
  logic [11:0]  addr, addr2;
  logic [255:0] rddata, rddata2, stage2;
  logic [15:0]  tdata, tdata2;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  fmap_stream_reader #(.RD_LATENCY(1)) u_dut (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start), .ch_sel(ch_sel),
    .busy(busy), .done(done), .err(err), .bram_addr_b(addr), .bram_en_b(en),
    .bram_rddata_b(rddata), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser));

  fmap_stream_reader #(.RD_LATENCY(2)) u_dut2 (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start2), .ch_sel(ch_sel2),
    .busy(busy2), .done(done2), .err(err2), .bram_addr_b(addr2), .bram_en_b(en2),
    .bram_rddata_b(rddata2), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready2), .m_axis_tlast(tlast2), .m_axis_tuser(tuser2));

  function automatic logic [255:0] mkword(input logic [11:0] a);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = {a[7:0], 8'(i)};
    return w;
  endfunction

  function automatic logic [15:0] exp_pix(input int ch, input int n);
    int c, r;
    logic [11:0] a;
    c = n / 24;
    r = n % 24;
    a = 12'(ch * 48 + c * 2 + r / 16);
    return {a[7:0], 8'(r % 16)};
  endfunction

  always @(posedge clk) begin
    if (en) rddata <= mkword(addr);
    if (en2) stage2 <= mkword(addr2);
    rddata2 <= stage2;
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; ch_sel = '0; ch_sel2 = '0;
    tready = 1'b1; tready2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, en, tvalid, tlast, tuser} !== 7'b0 || addr !== 12'h0 || tdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b tvalid=%b tlast=%b tuser=%b addr=%h tdata=%h, want all 0",
               busy, done, err, en, tvalid, tlast, tuser, addr, tdata);
    end
    checks++;
    if ({busy2, done2, err2, en2, tvalid2, tlast2, tuser2} !== 7'b0 || addr2 !== 12'h0) begin
      errors++;
      $display("FAIL reset_outputs2: busy=%b done=%b err=%b en=%b tvalid=%b addr=%h, want all 0",
               busy2, done2, err2, en2, tvalid2, addr2);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tvalid !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b tvalid=%b en=%b, want 0 0 0", busy, tvalid, en);
    end
  endtask

  // Full frame on the latency-1 instance with tready held high
  task automatic run_frame(input int ch, input bit mid_start);
    int beats, reads, first_v, done_cyc, done_cnt;
    logic [11:0] base;
    beats = 0; reads = 0; first_v = -1; done_cyc = -1; done_cnt = 0;
    base = 12'(ch * 48);
    tready = 1'b1;
    @(negedge clk); start = 1'b1; ch_sel = 3'(ch);
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      if (cyc == 1) begin
        checks++;
        if (en !== 1'b1 || addr !== base || busy !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL first_read ch%0d: en=%b addr=%h busy=%b err=%b, want 1 %h 1 0", ch, en, addr, busy, err, base);
        end
      end
      if (mid_start && cyc == 50) begin start = 1'b1; ch_sel = 3'd2; end
      if (mid_start && cyc == 51) start = 1'b0;
      if (en === 1'b1) begin
        checks++;
        if (addr !== 12'(int'(base) + reads)) begin
          errors++;
          $display("FAIL read_addr ch%0d #%0d: got %h want %h", ch, reads, addr, 12'(int'(base) + reads));
        end
        reads++;
      end
      if (tvalid === 1'b1 && first_v < 0) first_v = cyc;
      if (tvalid === 1'b1 && tready === 1'b1) begin
        checks++;
        if (tdata !== exp_pix(ch, beats) || tuser !== (beats == 0) || tlast !== (beats % 24 == 23)) begin
          errors++;
          $display("FAIL beat ch%0d #%0d: tdata=%h tuser=%b tlast=%b want %h %b %b", ch, beats,
                   tdata, tuser, tlast, exp_pix(ch, beats), (beats == 0), (beats % 24 == 23));
        end
        beats++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done ch%0d: got %b want 0", ch, busy);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    checks++;
    if (first_v != 3) begin
      errors++;
      $display("FAIL first_tvalid_cycle ch%0d: got %0d want 3", ch, first_v);
    end
    checks++;
    if (beats != 576 || reads != 48) begin
      errors++;
      $display("FAIL frame_counts ch%0d: beats=%0d reads=%0d want 576 48", ch, beats, reads);
    end
    checks++;
    if (done_cyc != 579 || done_cnt != 1) begin
      errors++;
      $display("FAIL done_timing ch%0d: cycle=%0d pulses=%0d want 579 1", ch, done_cyc, done_cnt);
    end
  endtask

  task automatic test_frame_ch0();
    run_frame(0, 1'b0);
  endtask

  task automatic test_frame_ch3();
    run_frame(3, 1'b0);
  endtask

  task automatic test_start_during_run();
    run_frame(1, 1'b1);
  endtask

  task automatic test_random_rdlat2();
    int beats, issued, popped, first_v, done_cnt;
    bit prev_stall;
    logic [15:0] prev_data;
    logic prev_last, prev_user;
    beats = 0; issued = 0; popped = 0; first_v = -1; done_cnt = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; prev_user = 1'b0;
    tready2 = 1'b0;
    @(negedge clk); start2 = 1'b1; ch_sel2 = 3'd0;
    @(negedge clk); start2 = 1'b0;
    for (int cyc = 1; cyc <= 5000; cyc++) begin
      if (prev_stall) begin
        checks++;
        if (tvalid2 !== 1'b1 || tdata2 !== prev_data || tlast2 !== prev_last || tuser2 !== prev_user) begin
          errors++;
          $display("FAIL stall_hold beat%0d: tvalid=%b tdata=%h tlast=%b tuser=%b want 1 %h %b %b",
                   beats, tvalid2, tdata2, tlast2, tuser2, prev_data, prev_last, prev_user);
        end
      end
      if (en2 === 1'b1) begin
        checks++;
        if (issued - popped >= 2) begin
          errors++;
          $display("FAIL outstanding cyc%0d: buffered+inflight=%0d want <2 before a read", cyc, issued - popped);
        end
        issued++;
      end
      if (tvalid2 === 1'b1 && first_v < 0) first_v = cyc;
      tready2 = 1'($urandom_range(0, 1));
      if (tvalid2 === 1'b1 && tready2 === 1'b1) begin
        checks++;
        if (tdata2 !== exp_pix(0, beats) || tuser2 !== (beats == 0) || tlast2 !== (beats % 24 == 23)) begin
          errors++;
          $display("FAIL rand_beat #%0d: tdata=%h tuser=%b tlast=%b want %h %b %b", beats,
                   tdata2, tuser2, tlast2, exp_pix(0, beats), (beats == 0), (beats % 24 == 23));
        end
        if (beats % 24 == 23 || beats % 24 == 15) popped++;
        beats++;
      end
      prev_stall = (tvalid2 === 1'b1) && (tready2 === 1'b0);
      prev_data = tdata2; prev_last = tlast2; prev_user = tuser2;
      if (done2 === 1'b1) done_cnt++;
      if (done_cnt > 0 && busy2 === 1'b0 && done2 === 1'b0) break;
      @(negedge clk);
    end
    tready2 = 1'b0;
    checks++;
    if (first_v != 4) begin
      errors++;
      $display("FAIL rand_first_tvalid: got %0d want 4", first_v);
    end
    checks++;
    if (beats != 576 || issued != 48 || done_cnt != 1) begin
      errors++;
      $display("FAIL rand_counts: beats=%0d reads=%0d done=%0d want 576 48 1", beats, issued, done_cnt);
    end
  endtask

  task automatic test_err_channel();
    int reads;
    reads = 0;
    @(negedge clk); start = 1'b1; ch_sel = 3'd5;
    @(negedge clk); start = 1'b0;
    if (en === 1'b1) reads++;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle1: busy=%b done=%b err=%b want 1 0 0", busy, done, err);
    end
    @(negedge clk);
    if (en === 1'b1) reads++;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_cycle2: done=%b err=%b busy=%b want 1 1 0", done, err, busy);
    end
    @(negedge clk);
    if (en === 1'b1) reads++;
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || reads != 0) begin
      errors++;
      $display("FAIL err_cycle3: done=%b err=%b reads=%0d want 0 1 0", done, err, reads);
    end
    run_frame(0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int beats;
    bit hit;
    beats = 0; hit = 1'b0;
    tready = 1'b1;
    @(negedge clk); start = 1'b1; ch_sel = 3'd0;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (tvalid === 1'b1 && tready === 1'b1) beats++;
      if (beats == 100) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_beat100: got %0d beats want 100", beats);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, en, tvalid, tlast, tuser} !== 7'b0 || addr !== 12'h0 || tdata !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b en=%b tvalid=%b tlast=%b tuser=%b addr=%h tdata=%h, want all 0",
               busy, done, err, en, tvalid, tlast, tuser, addr, tdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: done=%b tvalid=%b want 0 0", done, tvalid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame_ch0();
    test_frame_ch3();
    test_random_rdlat2();
    test_err_channel();
    test_start_during_run();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
